// File: rtl/rv32i_writeback_pkg.sv
// Shared encodings for the RV32I writeback stage: result select, load funct3 codes, FSM states.
package rv32i_writeback_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wbState_t;

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [2:0]  loadSize;
        logic [31:0] aluResult;
        logic [31:0] pcPlus4;
        logic [31:0] immExt;
        logic [4:0]  rd;
    } memWb_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Load extraction: picks byte/half/word by offset and sign/zero-extends; combinational, 0 cycles.
// No backpressure: pure function of its inputs.
module rv32i_load_align
    import rv32i_writeback_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  loadSize,
    output logic [31:0] value
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[7:0];
        case (offset)
            2'd0:    byteSel = word[7:0];
            2'd1:    byteSel = word[15:8];
            2'd2:    byteSel = word[23:16];
            default: byteSel = word[31:24];
        endcase
        // Halfword accesses ignore offset[0]; misaligned halves are not trapped here.
        halfSel = offset[1] ? word[31:16] : word[15:0];

        value = word;
        case (loadSize)
            LS_LB:   value = {{24{byteSel[7]}}, byteSel};
            LS_LH:   value = {{16{halfSel[15]}}, halfSel};
            LS_LBU:  value = {24'h0, byteSel};
            LS_LHU:  value = {16'h0, halfSel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback: MEM/WB register, load wait FSM, result mux; non-loads write 1 cycle after *M.
// Backpressure: StallW holds MEM/WB and upstream while a load waits for ReadValid (bounded by MAX_WAIT).
module rv32i_writeback
    import rv32i_writeback_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ImmExtM,
    input  logic [4:0]  RdM,
    input  logic        ReadValid,
    input  logic [31:0] ReadData,
    output logic        RegWriteW,
    output logic [4:0]  RdW,
    output logic [31:0] ResultW,
    output logic        StallW,
    output logic        LoadTimeoutW
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    memWb_t            memWbD;
    memWb_t            memWbQ;
    wbState_t          state;
    wbState_t          stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              pending;
    logic              atLimit;
    logic [31:0]       loadValue;

    assign memWbD = '{
        regWrite:  RegWriteM,
        resultSrc: ResultSrcM,
        loadSize:  LoadSizeM,
        aluResult: ALUResultM,
        pcPlus4:   PCPlus4M,
        immExt:    ImmExtM,
        rd:        RdM
    };

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memWbQ <= '0;
        end else if (!StallW) begin
            memWbQ <= memWbD;
        end
    end

    assign pending = memWbQ.regWrite && (memWbQ.resultSrc == RES_MEM);
    assign atLimit = (state == WB_WAIT) && (waitCnt == MAX_CNT);

    // A late ReadValid on the limit cycle still completes the load normally.
    assign StallW       = pending && !ReadValid && !atLimit;
    assign LoadTimeoutW = pending && !ReadValid && atLimit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WB_IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            WB_IDLE: begin
                if (pending && !ReadValid) begin
                    stateNext   = WB_WAIT;
                    waitCntNext = WAIT_W'(1);
                end
            end
            WB_WAIT: begin
                if (!pending || ReadValid || atLimit) begin
                    stateNext   = WB_IDLE;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                stateNext   = WB_IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    rv32i_load_align uAlign (
        .word     (ReadData),
        .offset   (memWbQ.aluResult[1:0]),
        .loadSize (memWbQ.loadSize),
        .value    (loadValue)
    );

    always_comb begin
        ResultW = memWbQ.aluResult;
        case (memWbQ.resultSrc)
            RES_ALU: ResultW = memWbQ.aluResult;
            RES_MEM: ResultW = loadValue;
            RES_PC4: ResultW = memWbQ.pcPlus4;
            default: ResultW = memWbQ.immExt;
        endcase
    end

    assign RdW       = memWbQ.rd;
    assign RegWriteW = memWbQ.regWrite && (memWbQ.rd != 5'd0) && !StallW && !LoadTimeoutW;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed bench for rv32i_writeback (MAX_WAIT=4); each output vector is {RegWriteW,RdW,ResultW,StallW,LoadTimeoutW}.
module tb_rv32i_writeback;
    import rv32i_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadSizeM;
    logic [31:0] ALUResultM;
    logic [31:0] PCPlus4M;
    logic [31:0] ImmExtM;
    logic [4:0]  RdM;
    logic        ReadValid;
    logic [31:0] ReadData;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        StallW;
    logic        LoadTimeoutW;

    logic [39:0] obs;
    logic [39:0] exp;
    int          nVec = 0;
    int          nErr = 0;

    rv32i_writeback #(.WAIT_W(8), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteM    (RegWriteM),
        .ResultSrcM   (ResultSrcM),
        .LoadSizeM    (LoadSizeM),
        .ALUResultM   (ALUResultM),
        .PCPlus4M     (PCPlus4M),
        .ImmExtM      (ImmExtM),
        .RdM          (RdM),
        .ReadValid    (ReadValid),
        .ReadData     (ReadData),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .StallW       (StallW),
        .LoadTimeoutW (LoadTimeoutW)
    );

    always #5 clk = ~clk;

    assign obs = {RegWriteW, RdW, ResultW, StallW, LoadTimeoutW};

    task automatic setM(input logic rw, input logic [1:0] src, input logic [2:0] sz,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [4:0] rd);
        RegWriteM  = rw;
        ResultSrcM = src;
        LoadSizeM  = sz;
        ALUResultM = alu;
        PCPlus4M   = pc4;
        ImmExtM    = imm;
        RdM        = rd;
    endtask

    task automatic bubble();
        setM(1'b0, RES_ALU, LS_LB, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setM(1'b1, RES_ALU, LS_LW, 32'h1111, 32'h0, 32'h0, 5'd4);
        ReadValid = 1'b0;
        ReadData  = 32'h0;
        #2;
        exp = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL reset_initial got %h want %h", obs, exp); end
        tick();
        #1;
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL reset_held got %h want %h", obs, exp); end
        rst = 1'b1;
        bubble();
    endtask

    task automatic test_alu();
        setM(1'b1, RES_ALU, LS_LW, 32'h1234, 32'h0, 32'h0, 5'd5);
        tick();
        bubble();
        #1;
        exp = {1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL alu_op got %h want %h", obs, exp); end
    endtask

    task automatic test_zero_latency();
        logic [2:0]  sz  [8] = '{LS_LB, LS_LBU, LS_LHU, LS_LH, LS_LH, LS_LBU, LS_LW, 3'b011};
        logic [1:0]  off [8] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2};
        logic [31:0] dat [8] = '{32'h0080FF00, 32'h0080FF00, 32'h0080FF00, 32'h12348001,
                                 32'h12348001, 32'h12348001, 32'hCAFEF00D, 32'hCAFEF00D};
        logic [31:0] res [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'hFFFF8001,
                                 32'h00001234, 32'h00000080, 32'hCAFEF00D, 32'hCAFEF00D};
        for (int i = 0; i < 8; i++) begin
            setM(1'b1, RES_MEM, sz[i], {30'h400, off[i]}, 32'h0, 32'h0, 5'd3);
            tick();
            bubble();
            ReadValid = 1'b1;
            ReadData  = dat[i];
            #1;
            exp = {1'b1, 5'd3, res[i], 1'b0, 1'b0};
            nVec++;
            if (obs !== exp) begin nErr++; $display("FAIL zero_lat_load[%0d] got %h want %h", i, obs, exp); end
        end
        tick();
        ReadValid = 1'b0;
    endtask

    task automatic test_multicycle();
        setM(1'b1, RES_MEM, LS_LW, 32'h100, 32'h0, 32'h0, 5'd7);
        tick();
        setM(1'b1, RES_ALU, LS_LW, 32'h55, 32'h0, 32'h0, 5'd9);
        ReadValid = 1'b0;
        ReadData  = 32'h0BAD0BAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp = {1'b0, 5'd7, 32'h0BAD0BAD, 1'b1, 1'b0};
            nVec++;
            if (obs !== exp) begin nErr++; $display("FAIL load_stall[%0d] got %h want %h", c, obs, exp); end
            tick();
        end
        ReadValid = 1'b1;
        ReadData  = 32'hDEADBEEF;
        #1;
        exp = {1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL load_late_data got %h want %h", obs, exp); end
        tick();
        ReadValid = 1'b0;
        bubble();
        #1;
        exp = {1'b1, 5'd9, 32'h00000055, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL after_stall_instr got %h want %h", obs, exp); end
    endtask

    task automatic test_timeout();
        setM(1'b1, RES_MEM, LS_LW, 32'h200, 32'h0, 32'h0, 5'd8);
        tick();
        setM(1'b1, RES_ALU, LS_LW, 32'h77, 32'h0, 32'h0, 5'd6);
        ReadValid = 1'b0;
        ReadData  = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp = {1'b0, 5'd8, 32'h12345678, 1'b1, 1'b0};
            nVec++;
            if (obs !== exp) begin nErr++; $display("FAIL timeout_stall[%0d] got %h want %h", c, obs, exp); end
            tick();
        end
        #1;
        exp = {1'b0, 5'd8, 32'h12345678, 1'b0, 1'b1};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL timeout_pulse got %h want %h", obs, exp); end
        tick();
        bubble();
        #1;
        exp = {1'b1, 5'd6, 32'h00000077, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL after_timeout got %h want %h", obs, exp); end
        // A fresh load must be handled from IDLE again: one stall then data.
        setM(1'b1, RES_MEM, LS_LW, 32'h300, 32'h0, 32'h0, 5'd2);
        tick();
        bubble();
        #1;
        exp = {1'b0, 5'd2, 32'h12345678, 1'b1, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL post_timeout_stall got %h want %h", obs, exp); end
        tick();
        ReadValid = 1'b1;
        #1;
        exp = {1'b1, 5'd2, 32'h12345678, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL post_timeout_load got %h want %h", obs, exp); end
        tick();
        ReadValid = 1'b0;
    endtask

    task automatic test_x0_link();
        setM(1'b1, RES_ALU, LS_LW, 32'hABC, 32'h0, 32'h0, 5'd0);
        tick();
        setM(1'b1, RES_PC4, LS_LW, 32'h999, 32'h104, 32'h0, 5'd1);
        ReadValid = 1'b1;
        ReadData  = 32'hFFFFFFFF;
        #1;
        exp = {1'b0, 5'd0, 32'h00000ABC, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL x0_write got %h want %h", obs, exp); end
        tick();
        setM(1'b1, RES_IMM, LS_LW, 32'h999, 32'h0, 32'hABCD_E000, 5'd31);
        ReadValid = 1'b0;
        #1;
        exp = {1'b1, 5'd1, 32'h00000104, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL jal_link got %h want %h", obs, exp); end
        tick();
        bubble();
        #1;
        exp = {1'b1, 5'd31, 32'hABCDE000, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL lui_imm got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_midwait();
        setM(1'b1, RES_MEM, LS_LW, 32'h500, 32'h0, 32'h0, 5'd10);
        tick();
        bubble();
        ReadValid = 1'b0;
        ReadData  = 32'h5A5A5A5A;
        tick();
        #1;
        exp = {1'b0, 5'd10, 32'h5A5A5A5A, 1'b1, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL midwait_stall got %h want %h", obs, exp); end
        rst = 1'b0;
        #1;
        exp = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL midwait_reset got %h want %h", obs, exp); end
        tick();
        rst = 1'b1;
        ReadValid = 1'b1;
        #1;
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL post_reset_release got %h want %h", obs, exp); end
        tick();
        #1;
        nVec++;
        if (obs !== exp) begin nErr++; $display("FAIL post_reset_no_write got %h want %h", obs, exp); end
        ReadValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_zero_latency();
        test_multicycle();
        test_timeout();
        test_x0_link();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
